// File: rtl/univ_shift_reg_n_if.sv
// Bus bundle for the universal shift register: per-cycle mode controls,
// serial fills, parallel data, the burst request and all register outputs.
//
// Burst handshake: start/dir/amt are sampled only while busy is low.
// Once a nonzero count is accepted, busy stays high until the last
// shift edge. done pulses for exactly one cycle after that edge, or one
// cycle after a zero-count start. A new start may be presented while
// done is high.
interface univ_shift_reg_n_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
);
  logic [2:0]       mode;
  logic             left_in;
  logic             right_in;
  logic [WIDTH-1:0] p_in;
  logic             start;
  logic             dir;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] p_out;
  logic             left_out;
  logic             right_out;
  logic             busy;
  logic             done;

  // Driving side (controller or testbench).
  modport master (
    output mode, left_in, right_in, p_in, start, dir, amt,
    input  p_out, left_out, right_out, busy, done
  );

  // Register side.
  modport slave (
    input  mode, left_in, right_in, p_in, start, dir, amt,
    output p_out, left_out, right_out, busy, done
  );
endinterface

// File: rtl/univ_shift_reg_n.sv
// WIDTH-bit universal shift register. Supports hold, logical shifts, load,
// rotates, arithmetic right shift and synchronous clear. It also has a
// counted burst-shift engine that reports progress with busy and done.
// All outputs come straight from flops, so no input reaches an output
// combinationally.
module univ_shift_reg_n #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic                  clk,
  input  logic                  clr_n,
  univ_shift_reg_n_if.slave     bus,
  output logic                  state_dbg
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_SHR   = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_LOAD  = 3'b011;
  localparam logic [2:0] M_ROR   = 3'b100;
  localparam logic [2:0] M_ROL   = 3'b101;
  localparam logic [2:0] M_ASR   = 3'b110;
  localparam logic [2:0] M_CLR   = 3'b111;

  localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

  state_t           state_q, state_n;
  logic [WIDTH-1:0] sreg_q, sreg_n;
  logic             lo_q, lo_n;
  logic             ro_q, ro_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             dir_q, dir_n;
  logic [AMT_W-1:0] cnt_q, cnt_n;

  // State register. Reset aborts any burst without producing done.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      lo_q    <= 1'b0;
      ro_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      sreg_q  <= sreg_n;
      lo_q    <= lo_n;
      ro_q    <= ro_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      dir_q   <= dir_n;
      cnt_q   <= cnt_n;
    end
  end

  // Next-state logic. In IDLE, start takes priority over mode. In BURST,
  // every edge performs one logical shift until the count runs out.
  always_comb begin
    state_n = state_q;
    sreg_n  = sreg_q;
    lo_n    = lo_q;
    ro_n    = ro_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    dir_n   = dir_q;
    cnt_n   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // Accept the burst and leave the register untouched on this edge.
          dir_n = bus.dir;
          cnt_n = bus.amt;
          if (bus.amt != '0) begin
            state_n = S_BURST;
            busy_n  = 1'b1;
          end else begin
            done_n  = 1'b1;
          end
        end else begin
          case (bus.mode)
            M_HOLD: begin
              sreg_n = sreg_q;
            end
            M_SHR: begin
              ro_n   = sreg_q[0];
              sreg_n = {bus.left_in, sreg_q[WIDTH-1:1]};
            end
            M_SHL: begin
              lo_n   = sreg_q[WIDTH-1];
              sreg_n = {sreg_q[WIDTH-2:0], bus.right_in};
            end
            M_LOAD: begin
              sreg_n = bus.p_in;
            end
            M_ROR: begin
              ro_n   = sreg_q[0];
              sreg_n = {sreg_q[0], sreg_q[WIDTH-1:1]};
            end
            M_ROL: begin
              lo_n   = sreg_q[WIDTH-1];
              sreg_n = {sreg_q[WIDTH-2:0], sreg_q[WIDTH-1]};
            end
            M_ASR: begin
              ro_n   = sreg_q[0];
              sreg_n = {sreg_q[WIDTH-1], sreg_q[WIDTH-1:1]};
            end
            M_CLR: begin
              sreg_n = '0;
              lo_n   = 1'b0;
              ro_n   = 1'b0;
            end
            default: begin
              sreg_n = sreg_q;
            end
          endcase
        end
      end

      S_BURST: begin
        // Fill bits are taken live on each shift edge, not latched at start.
        if (dir_q) begin
          lo_n   = sreg_q[WIDTH-1];
          sreg_n = {sreg_q[WIDTH-2:0], bus.right_in};
        end else begin
          ro_n   = sreg_q[0];
          sreg_n = {bus.left_in, sreg_q[WIDTH-1:1]};
        end
        cnt_n = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end

      default: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign bus.p_out     = sreg_q;
  assign bus.left_out  = lo_q;
  assign bus.right_out = ro_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign state_dbg     = (state_q == S_BURST);

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Directed and randomised bench for univ_shift_reg_n (WIDTH=8, AMT_W=4).
// Each step pushes the expected {p_out, left_out, right_out, busy, done}
// before the clock edge and pops it for comparison after the edge.
module tb_univ_shift_reg_n;

  localparam int W = 8;
  localparam int A = 4;

  logic clk;
  logic clr_n;
  logic state_dbg;

  univ_shift_reg_n_if #(.WIDTH(W), .AMT_W(A)) bus ();

  univ_shift_reg_n #(.WIDTH(W), .AMT_W(A)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [W+3:0] exp_q[$];
  string        tag_q[$];

  // Reference model state.
  logic [W-1:0] m_r;
  logic         m_lo;
  logic         m_ro;

  function automatic logic [W+3:0] pack(input logic [W-1:0] r, input logic lo,
                                        input logic ro, input logic b, input logic d);
    return {r, lo, ro, b, d};
  endfunction

  function automatic logic [W+3:0] observed();
    return {bus.p_out, bus.left_out, bus.right_out, bus.busy, bus.done};
  endfunction

  task automatic check(input string tag, input logic [W+3:0] obs, input logic [W+3:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, expv);
      $error("check %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [2:0] m, input logic li, input logic ri,
                       input logic [W-1:0] p, input logic st, input logic d,
                       input logic [A-1:0] a);
    bus.mode     = m;
    bus.left_in  = li;
    bus.right_in = ri;
    bus.p_in     = p;
    bus.start    = st;
    bus.dir      = d;
    bus.amt      = a;
  endtask

  // Push expectation, advance one edge, then pop and compare.
  task automatic tick(input logic [W+3:0] expv, input string tag);
    logic [W+3:0] e;
    string        t;
    exp_q.push_back(expv);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, observed(), e);
  endtask

  // Single-cycle mode model written in arithmetic form.
  task automatic model_op(input logic [2:0] m, input logic li, input logic ri,
                          input logic [W-1:0] p);
    case (m)
      3'd1: begin m_ro = m_r[0]; m_r = (m_r >> 1) | ({7'd0, li} << 7); end
      3'd2: begin m_lo = m_r[7]; m_r = (m_r << 1) | {7'd0, ri}; end
      3'd3: m_r = p;
      3'd4: begin m_ro = m_r[0]; m_r = (m_r >> 1) | ({7'd0, m_r[0]} << 7); end
      3'd5: begin m_lo = m_r[7]; m_r = (m_r << 1) | {7'd0, m_r[7]}; end
      3'd6: begin m_ro = m_r[0]; m_r = (m_r >> 1) | (m_r & 8'h80); end
      3'd7: begin m_r = 8'h00; m_lo = 1'b0; m_ro = 1'b0; end
      default: ;
    endcase
  endtask

  initial begin
    logic [W-1:0] v;
    logic         lo_e;
    logic [2:0]   rm;
    logic         rli, rri, rdir;
    logic [W-1:0] rp;
    int           ramt;

    clr_n = 1'b0;
    drive(3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", observed(), pack(8'h00, 0, 0, 0, 0));
    clr_n = 1'b1;

    // Asynchronous reset mid-cycle.
    drive(3'b011, 0, 0, 8'hA5, 0, 0, 0);
    tick(pack(8'hA5, 0, 0, 0, 0), "load_a5");
    drive(3'b000, 0, 0, 8'h00, 0, 0, 0);
    #2 clr_n = 1'b0;
    #1 check("async_reset", observed(), pack(8'h00, 0, 0, 0, 0));
    #1 clr_n = 1'b1;

    // Mode sweep.
    drive(3'b011, 0, 0, 8'h96, 0, 0, 0); tick(pack(8'h96, 0, 0, 0, 0), "load_96");
    drive(3'b001, 1, 0, 8'h00, 0, 0, 0); tick(pack(8'hCB, 0, 0, 0, 0), "shr");
    drive(3'b010, 0, 0, 8'h00, 0, 0, 0); tick(pack(8'h96, 1, 0, 0, 0), "shl");
    drive(3'b100, 0, 0, 8'h00, 0, 0, 0); tick(pack(8'h4B, 1, 0, 0, 0), "ror");
    drive(3'b101, 0, 0, 8'h00, 0, 0, 0); tick(pack(8'h96, 0, 0, 0, 0), "rol");
    drive(3'b110, 0, 0, 8'h00, 0, 0, 0); tick(pack(8'hCB, 0, 0, 0, 0), "asr");
    drive(3'b000, 1, 1, 8'h11, 0, 0, 0); tick(pack(8'hCB, 0, 0, 0, 0), "hold");
    drive(3'b001, 0, 0, 8'h00, 0, 0, 0); tick(pack(8'h65, 0, 1, 0, 0), "shr_ro1");
    drive(3'b111, 0, 0, 8'h00, 0, 0, 0); tick(pack(8'h00, 0, 0, 0, 0), "clear");

    // Burst right by 3.
    drive(3'b011, 0, 0, 8'h81, 0, 0, 0); tick(pack(8'h81, 0, 0, 0, 0), "load_81");
    drive(3'b000, 0, 0, 8'h00, 1, 0, 4'd3); tick(pack(8'h81, 0, 0, 1, 0), "bR_start");
    drive(3'b000, 0, 0, 8'h00, 0, 0, 0);
    tick(pack(8'h40, 0, 1, 1, 0), "bR_s1");
    tick(pack(8'h20, 0, 0, 1, 0), "bR_s2");
    tick(pack(8'h10, 0, 0, 0, 1), "bR_s3_done");
    tick(pack(8'h10, 0, 0, 0, 0), "bR_after");

    // Zero-count start: mode is ignored, done pulses once.
    drive(3'b011, 0, 0, 8'hFF, 1, 1, 4'd0); tick(pack(8'h10, 0, 0, 0, 1), "b0_done");
    drive(3'b000, 0, 0, 8'h00, 0, 0, 0);    tick(pack(8'h10, 0, 0, 0, 0), "b0_after");

    // Left burst of 12 with fill 1 on zero register.
    drive(3'b111, 0, 0, 8'h00, 0, 0, 0);    tick(pack(8'h00, 0, 0, 0, 0), "b12_clr");
    drive(3'b000, 0, 1, 8'h00, 1, 1, 4'd12); tick(pack(8'h00, 0, 0, 1, 0), "b12_start");
    drive(3'b000, 0, 1, 8'h00, 0, 0, 0);
    v = 8'h00;
    for (int k = 1; k <= 12; k++) begin
      lo_e = v[7];
      v = {v[6:0], 1'b1};
      tick(pack(v, lo_e, 0, (k < 12), (k == 12)), $sformatf("b12_s%0d", k));
    end

    // Inputs ignored while busy, then back-to-back start in the done cycle.
    drive(3'b011, 0, 0, 8'hF0, 0, 0, 0);    tick(pack(8'hF0, 1, 0, 0, 0), "load_f0");
    drive(3'b000, 1, 0, 8'h00, 1, 0, 4'd2); tick(pack(8'hF0, 1, 0, 1, 0), "bi_start");
    drive(3'b011, 1, 0, 8'h55, 1, 1, 4'd5); tick(pack(8'hF8, 1, 0, 1, 0), "bi_s1");
    tick(pack(8'hFC, 1, 0, 0, 1), "bi_s2_done");
    drive(3'b000, 0, 0, 8'h00, 1, 1, 4'd1); tick(pack(8'hFC, 1, 0, 1, 0), "b2b_start");
    drive(3'b000, 0, 0, 8'h00, 0, 0, 0);    tick(pack(8'hF8, 1, 0, 0, 1), "b2b_done");
    tick(pack(8'hF8, 1, 0, 0, 0), "b2b_after");

    // Reset mid-burst.
    drive(3'b011, 0, 0, 8'hFF, 0, 0, 0);     tick(pack(8'hFF, 1, 0, 0, 0), "load_ff");
    drive(3'b000, 0, 0, 8'h00, 1, 0, 4'd10); tick(pack(8'hFF, 1, 0, 1, 0), "bx_start");
    drive(3'b000, 0, 0, 8'h00, 0, 0, 0);
    tick(pack(8'h7F, 1, 1, 1, 0), "bx_s1");
    tick(pack(8'h3F, 1, 1, 1, 0), "bx_s2");
    tick(pack(8'h1F, 1, 1, 1, 0), "bx_s3");
    tick(pack(8'h0F, 1, 1, 1, 0), "bx_s4");
    #2 clr_n = 1'b0;
    #1 check("bx_abort", observed(), pack(8'h00, 0, 0, 0, 0));
    #1 clr_n = 1'b1;
    for (int k = 0; k < 3; k++) tick(pack(8'h00, 0, 0, 0, 0), $sformatf("bx_quiet%0d", k));
    drive(3'b011, 0, 0, 8'h5A, 0, 0, 0); tick(pack(8'h5A, 0, 0, 0, 0), "resume_load");
    drive(3'b001, 0, 0, 8'h00, 0, 0, 0); tick(pack(8'h2D, 0, 0, 0, 0), "resume_shr");

    // Random single-cycle mode ops against the model.
    m_r = 8'h2D; m_lo = 1'b0; m_ro = 1'b0;
    for (int i = 0; i < 40; i++) begin
      rm  = 3'($urandom_range(0, 7));
      rli = 1'($urandom_range(0, 1));
      rri = 1'($urandom_range(0, 1));
      rp  = 8'($urandom_range(0, 255));
      drive(rm, rli, rri, rp, 0, 0, 0);
      model_op(rm, rli, rri, rp);
      tick(pack(m_r, m_lo, m_ro, 0, 0), $sformatf("rnd_op%0d_m%0d", i, rm));
    end

    // Random bursts with per-edge random fill bits.
    for (int b = 0; b < 4; b++) begin
      rdir = 1'($urandom_range(0, 1));
      ramt = $urandom_range(1, 15);
      drive(3'($urandom_range(0, 7)), 0, 0, 8'h00, 1, rdir, 4'(ramt));
      tick(pack(m_r, m_lo, m_ro, 1, 0), $sformatf("rb%0d_start", b));
      for (int k = 1; k <= ramt; k++) begin
        rli = 1'($urandom_range(0, 1));
        rri = 1'($urandom_range(0, 1));
        drive(3'($urandom_range(0, 7)), rli, rri, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0, 4'd7);
        model_op(rdir ? 3'd2 : 3'd1, rli, rri, 8'h00);
        tick(pack(m_r, m_lo, m_ro, (k < ramt), (k == ramt)), $sformatf("rb%0d_s%0d", b, k));
      end
      drive(3'b000, 0, 0, 8'h00, 0, 0, 0);
      tick(pack(m_r, m_lo, m_ro, 0, 0), $sformatf("rb%0d_after", b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg_n.md
# univ_shift_reg_n

Parametrised universal shift register. Generalises the 4-bit universal shifter to WIDTH bits, adds rotate and arithmetic modes, and adds a counted burst-shift engine with a busy/done handshake. It sits in the lab datapath as the serial/parallel conversion stage.

## Interface
- WIDTH, 8, register width in bits (≥2)
- AMT_W, 4, width of the burst shift-count input
- clk  in  1  system clock, all state changes on rising edge
- clr_n  in  1  asynchronous, active-low reset
- mode  in  3  per-cycle operation select (IDLE only)
- left_in  in  1  serial fill bit entering the MSB on right shifts
- right_in  in  1  serial fill bit entering the LSB on left shifts
- p_in  in  WIDTH  parallel load data
- start  in  1  burst request, sampled in IDLE only
- dir  in  1  burst direction, 0 = right, 1 = left; sampled with start
- amt  in  AMT_W  burst shift count; sampled with start
- p_out  out  WIDTH  current register contents, driven directly by the register
- left_out  out  1  last bit shifted out of the MSB
- right_out  out  1  last bit shifted out of the LSB
- busy  out  1  high while a burst is in progress
- done  out  1  one-cycle pulse when a burst completes

## Operation
- Reset (clr_n low, asynchronous): register, left_out, right_out, busy, done all 0; FSM to IDLE; burst counter 0.
- FSM states: IDLE, BURST.
- IDLE, start=0: apply mode each edge.
  - 000 hold
  - 001 logical shift right: right_out←reg[0], reg←{left_in, reg[W-1:1]}
  - 010 logical shift left: left_out←reg[W-1], reg←{reg[W-2:0], right_in}
  - 011 parallel load reg←p_in; left_out/right_out unchanged
  - 100 rotate right: reg←{reg[0], reg[W-1:1]}; right_out←reg[0]
  - 101 rotate left: reg←{reg[W-2:0], reg[W-1]}; left_out←reg[W-1]
  - 110 arithmetic shift right: reg←{reg[W-1], reg[W-1:1]}; right_out←reg[0]
  - 111 clear reg to 0 (synchronous); left_out/right_out to 0
- Only the out bit on the shifted side updates; the other holds.
- IDLE, start=1: start has priority and mode is ignored on that edge. Latch dir, load counter←amt, and leave reg unchanged.
  - amt≠0: go to BURST and set busy=1.
  - amt=0: stay in IDLE; done=1 next cycle; busy never rises.
- BURST: each edge performs one logical shift in the latched dir, using left_in or right_in as sampled on that edge and updating right_out or left_out as in modes 001/010. Counter decrements on each such edge.
  - On the edge where the counter goes 1→0: shift, busy←0, done←1, go to IDLE.
- In BURST, mode, start, dir and amt are ignored.
- amt > WIDTH is legal: the register fully flushes with fill bits.
- done is 0 on every cycle except the one following burst completion, or the one following a zero-count start.
- Reset mid-burst aborts immediately: busy=0, no done pulse, register 0.

## Timing
- Single-cycle mode ops: the result is visible on p_out one cycle after the sampling edge.
- Burst: start is sampled at edge E. Shifts occur at edges E+1 … E+amt. busy is high from after E through edge E+amt. done is high for the cycle after E+amt.
- Back-to-back: start may be asserted in the same cycle done is high, because the FSM is already IDLE. That start is accepted.
- No combinational paths from inputs to outputs.

## Test plan
- Reset/async: WIDTH=8, load 0xA5, pulse clr_n low mid-cycle -> p_out=0x00, left_out=right_out=busy=done=0 before the next clk edge.
- Mode sweep: load 0x96; then apply 001 with left_in=1 -> 0xCB, right_out=0. Apply 010 with right_in=0 -> 0x96, left_out=1. Apply 100 -> 0x4B. Apply 101 -> 0x96. Apply 110 -> 0xCB. Apply 111 -> 0x00.
- Burst right: load 0x81, start dir=0 amt=3 left_in=0 -> busy high 3 cycles, p_out 0x40, 0x20, 0x10, right_out=0, done pulses exactly once after the third shift.
- Burst boundary: amt=0 -> p_out unchanged, busy stays 0, one done pulse. amt=12 left with right_in=1 on 0x00 -> 0xFF, left_out=1.
- Ignore during busy: in BURST, toggle mode=011 and start=1 -> no load, burst length unchanged. Issue a new start in the done cycle -> a second burst runs.
- Reset mid-burst: start amt=10, assert clr_n low after 4 shifts -> busy=0, p_out=0, no done pulse. Normal mode ops resume after release.
